// File: rtl/cargador_operandos_if.sv
`default_nettype none
// ============================================================================
// Module      : cargador_operandos_if
// Description : Board-side bundle for the operand loader: switch bus,
//               push-button, clear strobe and the loaded operand slots.
// Revision    : 1.0 - initial release
// ============================================================================
interface cargador_operandos_if #(
  parameter int CANT_BITS = 8,
  parameter int CANT_REG  = 3
);

  // Index width is at least one bit even for a two-slot configuration
  localparam int IDX_W = (CANT_REG > 2) ? $clog2(CANT_REG) : 1;

  logic [CANT_BITS-1:0]          entrada;
  logic                          boton;
  logic                          limpiar;
  logic [CANT_REG*CANT_BITS-1:0] registros;
  logic [IDX_W-1:0]              indice;
  logic                          completo;
  logic                          valido;

  // Board / testbench side: drives the switches and button
  modport master (
    output entrada,
    output boton,
    output limpiar,
    input  registros,
    input  indice,
    input  completo,
    input  valido
  );

  // Loader side
  modport slave (
    input  entrada,
    input  boton,
    input  limpiar,
    output registros,
    output indice,
    output completo,
    output valido
  );

endinterface
`default_nettype wire

// File: rtl/cargador_operandos.sv
`default_nettype none
// ============================================================================
// Module      : cargador_operandos
// Description : Synchronises and debounces a push-button; each clean press
//               stores the switch value into the next of CANT_REG operand
//               slots, flagging when a full set is loaded and wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module cargador_operandos #(
  parameter int CANT_BITS       = 8,
  parameter int CANT_REG        = 3,
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cargador_operandos_if.slave   bus
);

  localparam int c_IDX_W = (CANT_REG > 2) ? $clog2(CANT_REG) : 1;
  localparam int c_CNT_W = $clog2(DEBOUNCE_CICLOS + 1);

  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(CANT_REG - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [0:0] {
    CARGANDO = 1'b0,
    COMPLETO = 1'b1
  } estado_t;

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_estable;
  logic                 r_estable_d;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_flanco;

  estado_t              r_estado;
  logic [CANT_BITS-1:0] r_slots [CANT_REG];
  logic [c_IDX_W-1:0]   r_indice;
  logic                 r_completo;
  logic                 r_valido;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.boton;
      r_s2 <= r_s1;
    end
  end

  // Debouncer: accept a new level only after it persists long enough;
  // any return to the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estable <= 1'b0;
      r_cnt     <= '0;
    end else if (r_s2 == r_estable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_estable <= r_s2;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estable_d <= 1'b0;
    end else begin
      r_estable_d <= r_estable;
    end
  end

  assign w_flanco = r_estable & ~r_estable_d;

  // Slot-loading state machine; clear wins over a coincident press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= CARGANDO;
      r_indice   <= '0;
      r_completo <= 1'b0;
      r_valido   <= 1'b0;
      for (int i = 0; i < CANT_REG; i++) begin
        r_slots[i] <= '0;
      end
    end else if (bus.limpiar) begin
      r_estado   <= CARGANDO;
      r_indice   <= '0;
      r_completo <= 1'b0;
      r_valido   <= 1'b0;
      for (int i = 0; i < CANT_REG; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      r_valido <= 1'b0;
      if (w_flanco) begin
        case (r_estado)
          CARGANDO: begin
            for (int i = 0; i < CANT_REG; i++) begin
              if (r_indice == c_IDX_W'(i)) begin
                r_slots[i] <= bus.entrada;
              end
            end
            if (r_indice == c_IDX_LAST) begin
              r_indice   <= '0;
              r_completo <= 1'b1;
              r_valido   <= 1'b1;
              r_estado   <= COMPLETO;
            end else begin
              r_indice <= r_indice + 1'b1;
            end
          end
          COMPLETO: begin
            // First press of a new set; older slots stay until overwritten
            r_slots[0] <= bus.entrada;
            r_indice   <= c_IDX_W'(1);
            r_completo <= 1'b0;
            r_estado   <= CARGANDO;
          end
          default: begin
            r_estado <= CARGANDO;
          end
        endcase
      end
    end
  end

  generate
    for (genvar g = 0; g < CANT_REG; g++) begin : g_flat
      assign bus.registros[g*CANT_BITS +: CANT_BITS] = r_slots[g];
    end
  endgenerate

  assign bus.indice   = r_indice;
  assign bus.completo = r_completo;
  assign bus.valido   = r_valido;

endmodule
`default_nettype wire

// File: tb/tb_cargador_operandos.sv
`default_nettype none
// ============================================================================
// Module      : tb_cargador_operandos
// Description : Directed self-checking bench for cargador_operandos
//               (CANT_BITS=8, CANT_REG=3, DEBOUNCE_CICLOS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cargador_operandos;

  logic clk;
  logic rst_n;

  cargador_operandos_if #(.CANT_BITS(8), .CANT_REG(3)) bus ();

  cargador_operandos #(
    .CANT_BITS       (8),
    .CANT_REG        (3),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int   valido_cnt = 0;
  int   valido_dbl = 0;
  int   loads_cnt  = 0;
  logic prev_v     = 1'b0;
  logic [1:0] prev_idx = 2'd0;

  int runs [16] = '{1, 2, 3, 1, 2, 3, 1, 1, 3, 2, 2, 3, 1, 1, 3, 1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe valido pulses and index changes shortly after each edge
  always @(posedge clk) begin
    #2;
    if (bus.valido === 1'b1) begin
      valido_cnt++;
      if (prev_v === 1'b1) valido_dbl++;
    end
    prev_v = bus.valido;
    if (bus.indice !== prev_idx) loads_cnt++;
    prev_idx = bus.indice;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] v, input int hi, input int lo);
    bus.entrada = v;
    bus.boton   = 1'b1;
    repeat (hi) tick();
    bus.boton   = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.entrada = 8'h00;
    bus.boton   = 1'b0;
    bus.limpiar = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_registros", {8'h0, bus.registros}, 32'h0);
    check("reset_indice",    {30'h0, bus.indice},   32'h0);
    check("reset_completo",  {31'h0, bus.completo}, 32'h0);
    check("reset_valido",    {31'h0, bus.valido},   32'h0);

    // Single press: load appears on the 7th edge (E6) counting E0
    bus.entrada = 8'h5A;
    bus.boton   = 1'b1;
    repeat (6) tick();
    check("single_before_E6", {8'h0, bus.registros}, 32'h0);
    tick();
    check("single_registros", {8'h0, bus.registros}, 32'h0000_005A);
    check("single_indice",    {30'h0, bus.indice},   32'h1);
    check("single_completo",  {31'h0, bus.completo}, 32'h0);
    repeat (3) tick();
    bus.boton = 1'b0;
    repeat (10) tick();

    // Clear, then a full set
    bus.limpiar = 1'b1;
    tick();
    bus.limpiar = 1'b0;
    check("clear_registros", {8'h0, bus.registros}, 32'h0);
    check("clear_indice",    {30'h0, bus.indice},   32'h0);

    press(8'h11, 10, 10);
    press(8'h22, 10, 10);
    valido_cnt = 0;
    valido_dbl = 0;
    bus.entrada = 8'h33;
    bus.boton   = 1'b1;
    repeat (7) tick();
    check("set_valido_pulse", {31'h0, bus.valido},   32'h1);
    check("set_completo",     {31'h0, bus.completo}, 32'h1);
    tick();
    check("set_valido_drop",  {31'h0, bus.valido},   32'h0);
    repeat (2) tick();
    bus.boton = 1'b0;
    repeat (10) tick();
    check("set_registros",    {8'h0, bus.registros}, 32'h0033_2211);
    check("set_indice",       {30'h0, bus.indice},   32'h0);
    check("set_valido_count", valido_cnt,            32'd1);
    check("set_valido_double", valido_dbl,           32'd0);

    press(8'h44, 10, 10);
    check("wrap_registros", {8'h0, bus.registros}, 32'h0033_2244);
    check("wrap_indice",    {30'h0, bus.indice},   32'h1);
    check("wrap_completo",  {31'h0, bus.completo}, 32'h0);

    // Bounce: runs of 1-3 cycles never qualify, then a stable hold
    bus.entrada = 8'h77;
    loads_cnt   = 0;
    for (int i = 0; i < 16; i++) begin
      bus.boton = (i % 2 == 0);
      repeat (runs[i]) tick();
    end
    check("bounce_no_load", loads_cnt, 32'd0);
    bus.boton = 1'b1;
    repeat (10) tick();
    check("bounce_one_load",  loads_cnt,             32'd1);
    check("bounce_registros", {8'h0, bus.registros}, 32'h0033_7744);
    check("bounce_indice",    {30'h0, bus.indice},   32'h2);
    bus.boton = 1'b0;
    repeat (10) tick();

    // Clear coincides with the load edge of what would be the last slot
    bus.entrada = 8'h99;
    valido_cnt  = 0;
    bus.boton   = 1'b1;
    repeat (6) tick();
    bus.limpiar = 1'b1;
    tick();
    bus.limpiar = 1'b0;
    check("collide_registros", {8'h0, bus.registros}, 32'h0);
    check("collide_indice",    {30'h0, bus.indice},   32'h0);
    check("collide_completo",  {31'h0, bus.completo}, 32'h0);
    tick();
    check("collide_no_valido", valido_cnt, 32'd0);
    repeat (3) tick();
    bus.boton = 1'b0;
    repeat (10) tick();
    press(8'hAB, 10, 10);
    check("after_clear_registros", {8'h0, bus.registros}, 32'h0000_00AB);
    check("after_clear_indice",    {30'h0, bus.indice},   32'h1);

    // Held button: exactly one load
    bus.entrada = 8'hC3;
    loads_cnt   = 0;
    bus.boton   = 1'b1;
    repeat (200) tick();
    check("held_one_load",  loads_cnt,             32'd1);
    check("held_registros", {8'h0, bus.registros}, 32'h0000_C3AB);
    check("held_indice",    {30'h0, bus.indice},   32'h2);
    bus.boton = 1'b0;
    repeat (10) tick();
    press(8'hD4, 10, 10);
    check("held_second_registros", {8'h0, bus.registros}, 32'h00D4_C3AB);
    check("held_second_completo",  {31'h0, bus.completo}, 32'h1);

    // Asynchronous reset mid-debounce, checked before any clock edge
    bus.entrada = 8'hE1;
    bus.boton   = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_registros", {8'h0, bus.registros}, 32'h0);
    check("async_indice",    {30'h0, bus.indice},   32'h0);
    check("async_completo",  {31'h0, bus.completo}, 32'h0);
    check("async_valido",    {31'h0, bus.valido},   32'h0);
    repeat (3) tick();
    bus.boton = 1'b0;
    rst_n     = 1'b1;
    repeat (2) tick();
    press(8'h3C, 10, 10);
    check("post_reset_registros", {8'h0, bus.registros}, 32'h0000_003C);
    check("post_reset_indice",    {30'h0, bus.indice},   32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
